// File: rtl/synth_pkg.sv
// Shared constants for the PWM voice bank: channel count, carrier range,
// register address map and field widths.
package synth_pkg;

  localparam int NUM_CH      = 8;
  localparam int CARRIER_MAX = 254;

  localparam int ADDR_W      = 4;
  localparam int DATA_W      = 16;
  localparam int PERIOD_W    = 16;
  localparam int VOL_W       = 8;
  localparam int CARRIER_W   = 8;

  localparam int PERIOD_BASE = 0;
  localparam int VOL_BASE    = 8;

  // Register address of channel ch within the bank starting at base.
  function automatic logic [ADDR_W-1:0] ch_addr(input int base, input int ch);
    return ADDR_W'(base + ch);
  endfunction

endpackage

// File: rtl/pwm_voice.sv
// One voice: period/volume registers, half-period tone counter, square-wave
// phase and the registered carrier compare that forms the PWM output.
module pwm_voice
  import synth_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_period_we,
  input  logic                 i_vol_we,
  input  logic [DATA_W-1:0]    i_wr_data,
  input  logic [CARRIER_W-1:0] i_carrier,
  output logic                 o_pwm,
  output logic                 o_tone
);

  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_cnt;
  logic [VOL_W-1:0]    r_vol;
  logic                r_phase;
  logic                r_pwm;
  logic                r_tone;

  logic                w_silent;
  logic                w_terminal;

  assign w_silent   = (r_period == '0);
  assign w_terminal = (r_cnt == r_period - PERIOD_W'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_period <= '0;
      r_cnt    <= '0;
      r_vol    <= '0;
      r_phase  <= 1'b0;
      r_pwm    <= 1'b0;
      r_tone   <= 1'b0;
    end else begin
      if (i_vol_we) begin
        r_vol <= i_wr_data[VOL_W-1:0];
      end

      // A period write restarts the half-period count but keeps the phase,
      // and it overrides a terminal-count toggle landing on the same edge.
      if (i_period_we) begin
        r_period <= i_wr_data[PERIOD_W-1:0];
        r_cnt    <= '0;
      end else if (w_silent) begin
        r_cnt    <= '0;
        r_phase  <= 1'b0;
      end else if (w_terminal) begin
        r_cnt    <= '0;
        r_phase  <= ~r_phase;
      end else begin
        r_cnt    <= r_cnt + PERIOD_W'(1);
      end

      r_tone <= r_phase;
      r_pwm  <= r_phase & (i_carrier < r_vol);
    end
  end

  assign o_pwm  = r_pwm;
  assign o_tone = r_tone;

endmodule

// File: rtl/pwm_voice_bank.sv
// Bank of square-wave PWM voices sharing one amplitude carrier counter;
// decodes core register writes into per-channel period and volume strobes.
module pwm_voice_bank #(
  parameter int NUM_CH      = synth_pkg::NUM_CH,
  parameter int CARRIER_MAX = synth_pkg::CARRIER_MAX
) (
  input  logic                           clk_io,
  input  logic                           reset_io,
  input  logic                           wr_en_i,
  input  logic [synth_pkg::ADDR_W-1:0]   wr_addr_i,
  input  logic [synth_pkg::DATA_W-1:0]   wr_data_i,
  output logic [NUM_CH-1:0]              pwm_o,
  output logic [NUM_CH-1:0]              tone_o
);

  import synth_pkg::*;

  logic [CARRIER_W-1:0] r_carrier;
  logic [NUM_CH-1:0]    w_period_we;
  logic [NUM_CH-1:0]    w_vol_we;
  logic [NUM_CH-1:0]    w_pwm;
  logic [NUM_CH-1:0]    w_tone;

  // Carrier runs 0..CARRIER_MAX so a volume of 255 never drops out.
  always_ff @(posedge clk_io or posedge reset_io) begin
    if (reset_io) begin
      r_carrier <= '0;
    end else if (r_carrier == CARRIER_W'(CARRIER_MAX)) begin
      r_carrier <= '0;
    end else begin
      r_carrier <= r_carrier + CARRIER_W'(1);
    end
  end

  always_comb begin
    w_period_we = '0;
    w_vol_we    = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      w_period_we[n] = wr_en_i && (wr_addr_i == ch_addr(PERIOD_BASE, n));
      w_vol_we[n]    = wr_en_i && (wr_addr_i == ch_addr(VOL_BASE, n));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_voice
    pwm_voice u_voice (
      .i_clk       (clk_io),
      .i_rst       (reset_io),
      .i_period_we (w_period_we[g]),
      .i_vol_we    (w_vol_we[g]),
      .i_wr_data   (wr_data_i),
      .i_carrier   (r_carrier),
      .o_pwm       (w_pwm[g]),
      .o_tone      (w_tone[g])
    );
  end

  assign pwm_o  = w_pwm;
  assign tone_o = w_tone;

endmodule

// File: tb/tb_pwm_voice_bank.sv
// Directed bench for pwm_voice_bank: expectations are queued per absolute
// cycle and a negedge monitor compares them against pwm_o / tone_o.
module tb_pwm_voice_bank;

  typedef struct packed {
    logic [31:0] cyc;
    logic        kind;   // 0: tone_o, 1: pwm_o
    logic [7:0]  mask;
    logic [7:0]  val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [7:0]  pwm;
  logic [7:0]  tone;

  logic [31:0] cyc = 32'd0;
  logic [31:0] last_we;
  logic [31:0] rel_cyc;

  exp_t exp_q[$];
  exp_t keep_q[$];

  int checks   = 0;
  int failures = 0;

  pwm_voice_bank #(.NUM_CH(8), .CARRIER_MAX(254)) dut (
    .clk_io    (clk),
    .reset_io  (rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .pwm_o     (pwm),
    .tone_o    (tone)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at cyc %0d: actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic push(input logic [31:0] c, input logic kind, input logic [7:0] mask,
                      input logic [7:0] val);
    exp_t e;
    e.cyc  = c;
    e.kind = kind;
    e.mask = mask;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  function automatic int carrier_at(input logic [31:0] k);
    return int'((k - rel_cyc) % 32'd255);
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    keep_q.delete();
    foreach (exp_q[i]) begin
      if (exp_q[i].cyc == cyc) begin
        if (exp_q[i].kind)
          check("pwm_o", {24'd0, pwm & exp_q[i].mask}, {24'd0, exp_q[i].val & exp_q[i].mask});
        else
          check("tone_o", {24'd0, tone & exp_q[i].mask}, {24'd0, exp_q[i].val & exp_q[i].mask});
      end else if (exp_q[i].cyc < cyc) begin
        check("stale_expectation_cycle", cyc, exp_q[i].cyc);
      end else begin
        keep_q.push_back(exp_q[i]);
      end
    end
    exp_q = keep_q;
  end

  // driver tasks: all called at posedge+1, return at posedge+1
  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    last_we = cyc + 32'd1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wr_at(input logic [31:0] t, input logic [3:0] a, input logic [15:0] d);
    while (cyc < t - 32'd1) begin
      @(posedge clk);
      #1;
    end
    wr(a, d);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL queue_drain: pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    wait_drain();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rel_cyc = cyc;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    int e, tt, n, cnt;
    logic [31:0] wp[8];
    logic [31:0] lw;
    logic [7:0]  tv, pv;

    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_pwm", {24'd0, pwm}, 32'd0);
    check("reset_tone", {24'd0, tone}, 32'd0);
    rst = 1'b0;
    rel_cyc = cyc;
    for (int c = 1; c <= 5; c++) push(cyc + c, 1'b0, 8'hff, 8'h00);

    // tone: ch2 period 4, vol 255
    wr(4'd2, 16'd4);
    e = int'(last_we);
    wr(4'd10, 16'd255);
    for (int c = e + 2; c <= e + 25; c++) begin
      tv = ((((c - 1 - e) / 4) & 1) != 0) ? 8'h04 : 8'h00;
      push(c, 1'b0, 8'hff, tv);
      push(c, 1'b1, 8'hff, tv);
    end

    // boundaries: ch1 period 1 vol 0, ch3 period 0 vol 255
    do_reset();
    wr(4'd1, 16'd1);
    e = int'(last_we);
    wr(4'd9, 16'd0);
    wr(4'd11, 16'd255);
    wr(4'd3, 16'd0);
    for (int c = e + 4; c <= e + 19; c++) begin
      tv = (((c - 1 - e) & 1) != 0) ? 8'h02 : 8'h00;
      push(c, 1'b0, 8'hff, tv);
      push(c, 1'b1, 8'hff, 8'h00);
    end

    // period write on terminal count: ch4 period 5 -> 3
    do_reset();
    wr(4'd4, 16'd5);
    e  = int'(last_we);
    tt = e + 10;
    for (int c = e + 1; c <= tt + 13; c++) begin
      n = 0;
      if (c - 1 >= e + 5) n = n + 1;
      if (c - 1 >= tt + 3) n = n + 1 + (c - 1 - tt - 3) / 3;
      push(c, 1'b0, 8'hff, ((n & 1) != 0) ? 8'h10 : 8'h00);
    end
    wr_at(tt, 4'd4, 16'd3);

    // all channels: periods 2..9, vol 128
    do_reset();
    for (int ch = 0; ch < 8; ch++) begin
      wr(4'(ch), 16'(ch + 2));
      wp[ch] = last_we;
      wr(4'(8 + ch), 16'd128);
    end
    lw = cyc;
    for (int c = int'(lw) + 1; c <= int'(lw) + 160; c++) begin
      tv = 8'h00;
      for (int ch = 0; ch < 8; ch++)
        if ((((c - 1 - int'(wp[ch])) / (ch + 2)) & 1) != 0) tv[ch] = 1'b1;
      pv = (carrier_at(c - 1) < 128) ? tv : 8'h00;
      push(c, 1'b0, 8'hff, tv);
      push(c, 1'b1, 8'hff, pv);
    end

    // duty: ch0 period 1000 vol 64
    do_reset();
    wr(4'd0, 16'd1000);
    e = int'(last_we);
    wr(4'd8, 16'd64);
    push(e + 1000, 1'b0, 8'h01, 8'h00);
    push(e + 1000, 1'b1, 8'h01, 8'h00);
    push(e + 1001, 1'b0, 8'h01, 8'h01);
    push(e + 1255, 1'b0, 8'h01, 8'h01);
    for (int c = e + 1001; c <= e + 1255; c++)
      push(c, 1'b1, 8'h01, (carrier_at(c - 1) < 64) ? 8'h01 : 8'h00);
    while (int'(cyc) < e + 1001) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 255; i++) begin
      #1;
      cnt = cnt + int'(pwm[0]);
      @(negedge clk);
    end
    check("duty_high_count", cnt, 32'd64);
    @(posedge clk);
    #1;

    // mid-run reset with ch0 active
    do_reset();
    wr(4'd0, 16'd3);
    e = int'(last_we);
    wr(4'd8, 16'd255);
    for (int c = e + 2; c <= e + 4; c++) begin
      tv = ((((c - 1 - e) / 3) & 1) != 0) ? 8'h01 : 8'h00;
      push(c, 1'b0, 8'hff, tv);
      push(c, 1'b1, 8'hff, tv);
    end
    while (int'(cyc) < e + 5) begin
      @(posedge clk);
      #1;
    end
    check("pre_reset_tone", {24'd0, tone}, 32'h01);
    check("pre_reset_pwm", {24'd0, pwm}, 32'h01);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_tone", {24'd0, tone}, 32'd0);
    check("async_reset_pwm", {24'd0, pwm}, 32'd0);
    wr(4'd0, 16'd2);
    wr(4'd8, 16'd255);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rel_cyc = cyc;
    for (int c = 1; c <= 30; c++) begin
      push(cyc + c, 1'b0, 8'hff, 8'h00);
      push(cyc + c, 1'b1, 8'hff, 8'h00);
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_voice_bank.md
PWM_VOICE_BANK -- requirements
Module: pwm_voice_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of voice channels.
REQ-002 SHALL have parameter CARRIER_MAX, default 254, last value of the shared amplitude carrier counter.
REQ-003 SHALL have port clk_io, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_io, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port wr_en_i, input, 1, core register-write strobe, one write per asserted cycle.
REQ-006 SHALL have port wr_addr_i, input, 4, register address: 0-7 channel period, 8-15 channel volume.
REQ-007 SHALL have port wr_data_i, input, 16, write data.
REQ-008 SHALL have port pwm_o, output, NUM_CH, registered PWM audio outputs; bit n drives pwm<n>_io.
REQ-009 SHALL have port tone_o, output, NUM_CH, registered square-wave phase per channel, for debug and verification.

Function
REQ-010 SHALL accept every write on any cycle with wr_en_i=1; no back-pressure, no readback.
REQ-011 SHALL store period[n] = wr_data_i[15:0] on a write to address n (0-7).
REQ-012 SHALL store vol[n] = wr_data_i[7:0] on a write to address 8+n; wr_data_i[15:8] ignored.
REQ-013 SHALL keep a free-running 8-bit carrier counter counting 0..CARRIER_MAX, then wrapping to 0 (255-cycle frame).
REQ-014 SHALL keep, per channel, a 16-bit tone counter and a tone phase bit.
REQ-015 SHALL increment the tone counter each cycle when period[n]!=0; when tone counter == period[n]-1, it SHALL clear to 0 and toggle the phase (square-wave half-period = period[n] cycles).
REQ-016 SHALL hold tone counter and phase at 0 while period[n]==0 (channel silent).
REQ-017 SHALL, on a period write to channel n, clear that channel's tone counter in the same edge, keep its phase, and use the new period from the next cycle; the write takes priority over a simultaneous terminal-count toggle, so no toggle occurs that cycle.
REQ-018 SHALL leave other channels unaffected by any write.
REQ-019 SHALL register pwm_o[n] = phase[n] AND (carrier < vol[n]), one clock after phase and carrier values.
REQ-020 SHALL treat vol=0 as always 0 and vol=255 as constant phase (carrier never reaches 255).
REQ-021 SHALL apply a volume write to the pwm_o compare on the cycle after the write edge.
REQ-022 SHALL register tone_o[n] = phase[n] with the same one-cycle latency as pwm_o.

Reset
REQ-023 SHALL, while reset_io=1, force every period, vol, tone counter, phase, carrier counter, pwm_o and tone_o to 0 immediately (asynchronously).
REQ-024 SHALL ignore writes while reset_io=1; reset asserted mid-tone SHALL abandon the waveform, and after release all channels restart silent with carrier at 0.
REQ-025 SHALL begin counting on the first rising edge after reset_io deasserts.

Structure
REQ-026 SHALL take NUM_CH, CARRIER_MAX, the address map constants (PERIOD_BASE=0, VOL_BASE=8) and the period and volume widths from shared package synth_pkg.
REQ-027 SHALL instantiate sub-module pwm_voice NUM_CH times: one channel's period/vol registers, tone counter, phase and output compare; the carrier counter and address decode SHALL stay in pwm_voice_bank.

Verification
REQ-028 SHALL check reset: assert reset_io mid-run with channel 0 active -> pwm_o=0, tone_o=0 at once; after release, no toggle without new writes.
REQ-029 SHALL check tone: period[2]=4, vol[2]=255 -> tone_o[2] toggles every 4 cycles, pwm_o[2] equals tone_o[2], other bits 0.
REQ-030 SHALL check duty: period[0]=1000, vol[0]=64 -> during a high phase pwm_o[0] is high exactly 64 of each 255-cycle carrier frame.
REQ-031 SHALL check boundaries: period=1 toggles every cycle; period=0 holds tone 0; vol=0 gives pwm_o 0 while tone_o toggles.
REQ-032 SHALL check a period write coinciding with terminal count (period 5 -> 3): no toggle that cycle, next toggle exactly 3 cycles later.
REQ-033 SHALL check all 8 channels with distinct periods 2..9 and vol 128 -> each tone_o[n] half-period correct, no cross-channel interference.
